// File: rtl/culsans_exit_monitor.sv
// Multi-hart tohost end-of-test monitor: captures per-hart exit words, records the
// first failing hart, and ends the test on all/any exit, early fail or watchdog expiry.
module culsans_exit_monitor #(
    parameter int          NumHarts      = 2,
    parameter int          DataWidth     = 32,
    parameter bit          WaitAll       = 1'b1,
    parameter bit          StopOnFail    = 1'b1,
    parameter logic [31:0] TimeoutCycles = 32'd0,
    localparam int         HartIdxWidth  = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst,
    input  logic [NumHarts-1:0]                 tohost_valid_i,
    input  logic [NumHarts-1:0][DataWidth-1:0]  tohost_data_i,
    output logic [NumHarts-1:0]                 hart_exited_o,
    output logic                                done_o,
    output logic                                pass_o,
    output logic                                timeout_o,
    output logic [HartIdxWidth-1:0]             fail_hart_o,
    output logic [DataWidth-2:0]                exit_code_o,
    output logic [31:0]                         cycle_count_o
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    state_e                   state_r, state_n_s;
    logic [NumHarts-1:0]      hart_exited_r, hart_exited_n_s;
    logic [NumHarts-1:0]      capture_s, exited_all_s;
    logic                     done_r, done_n_s;
    logic                     pass_r, pass_n_s;
    logic                     timeout_r, timeout_n_s;
    logic                     fail_rec_r, fail_rec_n_s;
    logic [HartIdxWidth-1:0]  fail_hart_r, fail_hart_n_s, fail_idx_s;
    logic [DataWidth-2:0]     exit_code_r, exit_code_n_s, fail_code_s;
    logic [31:0]              cycle_count_r, cycle_count_n_s;
    logic                     fail_found_s, exit_s, timeout_hit_s;

    // Per-hart capture of first exit word; lowest-index nonzero code wins this cycle.
    always_comb begin
        capture_s    = '0;
        fail_found_s = 1'b0;
        fail_idx_s   = '0;
        fail_code_s  = '0;
        for (int i = 0; i < NumHarts; i++) begin
            if (tohost_valid_i[i] && tohost_data_i[i][0] && !hart_exited_r[i]) begin
                capture_s[i] = 1'b1;
                if (!fail_found_s && (tohost_data_i[i][DataWidth-1:1] != '0)) begin
                    fail_found_s = 1'b1;
                    fail_idx_s   = HartIdxWidth'(i);
                    fail_code_s  = tohost_data_i[i][DataWidth-1:1];
                end else begin
                    fail_found_s = fail_found_s;
                end
            end else begin
                capture_s[i] = 1'b0;
            end
        end
    end

    assign exited_all_s = hart_exited_r | capture_s;

    // Exit conditions from this cycle's captures; watchdog only fires when no exit does.
    always_comb begin
        exit_s = 1'b0;
        if (StopOnFail && fail_found_s) begin
            exit_s = 1'b1;
        end else if (WaitAll && (&exited_all_s)) begin
            exit_s = 1'b1;
        end else if (!WaitAll && (|capture_s)) begin
            exit_s = 1'b1;
        end else begin
            exit_s = 1'b0;
        end
        timeout_hit_s = (TimeoutCycles != 32'd0) &&
                        (cycle_count_r == (TimeoutCycles - 32'd1)) && !exit_s;
    end

    // Next-state and next-output logic; DONE holds everything until reset.
    always_comb begin
        state_n_s       = state_r;
        hart_exited_n_s = hart_exited_r;
        done_n_s        = done_r;
        pass_n_s        = pass_r;
        timeout_n_s     = timeout_r;
        fail_rec_n_s    = fail_rec_r;
        fail_hart_n_s   = fail_hart_r;
        exit_code_n_s   = exit_code_r;
        cycle_count_n_s = cycle_count_r;
        case (state_r)
            ST_RUN: begin
                hart_exited_n_s = exited_all_s;
                if (cycle_count_r != 32'hFFFF_FFFF) begin
                    cycle_count_n_s = cycle_count_r + 32'd1;
                end else begin
                    cycle_count_n_s = cycle_count_r;
                end
                if (fail_found_s && !fail_rec_r) begin
                    fail_rec_n_s  = 1'b1;
                    fail_hart_n_s = fail_idx_s;
                    exit_code_n_s = fail_code_s;
                end else begin
                    fail_rec_n_s  = fail_rec_r;
                end
                if (exit_s || timeout_hit_s) begin
                    state_n_s   = ST_DONE;
                    done_n_s    = 1'b1;
                    timeout_n_s = timeout_hit_s;
                    pass_n_s    = !(fail_rec_r || fail_found_s || timeout_hit_s);
                end else begin
                    state_n_s   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_n_s = ST_DONE;
            end
            default: begin
                state_n_s = ST_DONE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_RUN;
            hart_exited_r <= '0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_r     <= 1'b0;
            fail_rec_r    <= 1'b0;
            fail_hart_r   <= '0;
            exit_code_r   <= '0;
            cycle_count_r <= 32'd0;
        end else begin
            state_r       <= state_n_s;
            hart_exited_r <= hart_exited_n_s;
            done_r        <= done_n_s;
            pass_r        <= pass_n_s;
            timeout_r     <= timeout_n_s;
            fail_rec_r    <= fail_rec_n_s;
            fail_hart_r   <= fail_hart_n_s;
            exit_code_r   <= exit_code_n_s;
            cycle_count_r <= cycle_count_n_s;
        end
    end

    assign hart_exited_o = hart_exited_r;
    assign done_o        = done_r;
    assign pass_o        = pass_r;
    assign timeout_o     = timeout_r;
    assign fail_hart_o   = fail_hart_r;
    assign exit_code_o   = exit_code_r;
    assign cycle_count_o = cycle_count_r;

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Scoreboard bench: four monitor configurations; expected end-of-test records are
// queued by the stimulus and checked by a monitor on each rising done_o.
module tb_culsans_exit_monitor;

    typedef struct {
        int          dut;
        logic [1:0]  exited;
        logic        pass;
        logic        tmo;
        logic        fh;
        logic [30:0] code;
        logic [31:0] count;
    } exp_t;

    logic              clk = 1'b0;
    logic [3:0]        rst_v;
    logic [1:0]        valid_v [4];
    logic [1:0][31:0]  data_v  [4];
    logic [1:0]        exited_v[4];
    logic              done_v  [4];
    logic              pass_v  [4];
    logic              tmo_v   [4];
    logic [0:0]        fh_v    [4];
    logic [30:0]       code_v  [4];
    logic [31:0]       count_v [4];
    logic              done_prev[4];

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    culsans_exit_monitor #(.NumHarts(2), .DataWidth(32), .WaitAll(1'b1), .StopOnFail(1'b1),
                           .TimeoutCycles(32'd0)) dut_a (
        .clk_i(clk), .rst(rst_v[0]), .tohost_valid_i(valid_v[0]), .tohost_data_i(data_v[0]),
        .hart_exited_o(exited_v[0]), .done_o(done_v[0]), .pass_o(pass_v[0]), .timeout_o(tmo_v[0]),
        .fail_hart_o(fh_v[0]), .exit_code_o(code_v[0]), .cycle_count_o(count_v[0]));

    culsans_exit_monitor #(.NumHarts(2), .DataWidth(32), .WaitAll(1'b1), .StopOnFail(1'b1),
                           .TimeoutCycles(32'd100)) dut_t (
        .clk_i(clk), .rst(rst_v[1]), .tohost_valid_i(valid_v[1]), .tohost_data_i(data_v[1]),
        .hart_exited_o(exited_v[1]), .done_o(done_v[1]), .pass_o(pass_v[1]), .timeout_o(tmo_v[1]),
        .fail_hart_o(fh_v[1]), .exit_code_o(code_v[1]), .cycle_count_o(count_v[1]));

    culsans_exit_monitor #(.NumHarts(2), .DataWidth(32), .WaitAll(1'b0), .StopOnFail(1'b0),
                           .TimeoutCycles(32'd8)) dut_b (
        .clk_i(clk), .rst(rst_v[2]), .tohost_valid_i(valid_v[2]), .tohost_data_i(data_v[2]),
        .hart_exited_o(exited_v[2]), .done_o(done_v[2]), .pass_o(pass_v[2]), .timeout_o(tmo_v[2]),
        .fail_hart_o(fh_v[2]), .exit_code_o(code_v[2]), .cycle_count_o(count_v[2]));

    culsans_exit_monitor #(.NumHarts(2), .DataWidth(32), .WaitAll(1'b1), .StopOnFail(1'b0),
                           .TimeoutCycles(32'd0)) dut_c (
        .clk_i(clk), .rst(rst_v[3]), .tohost_valid_i(valid_v[3]), .tohost_data_i(data_v[3]),
        .hart_exited_o(exited_v[3]), .done_o(done_v[3]), .pass_o(pass_v[3]), .timeout_o(tmo_v[3]),
        .fail_hart_o(fh_v[3]), .exit_code_o(code_v[3]), .cycle_count_o(count_v[3]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [1:0] ex, input logic p, input logic t,
                        input logic fh, input logic [30:0] c, input logic [31:0] n);
        exp_t e;
        e.dut = d; e.exited = ex; e.pass = p; e.tmo = t; e.fh = fh; e.code = c; e.count = n;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input int k, input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        valid_v[k]   = v;
        data_v[k][0] = d0;
        data_v[k][1] = d1;
        tick();
        valid_v[k]   = 2'b00;
        data_v[k][0] = 32'd0;
        data_v[k][1] = 32'd0;
    endtask

    task automatic start(input int k);
        rst_v = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            valid_v[j]   = 2'b00;
            data_v[j][0] = 32'd0;
            data_v[j][1] = 32'd0;
        end
        idle(2);
        rst_v[k] = 1'b1;
    endtask

    // Monitor: each rising done_o pops one expected record and compares every field.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_v[k] && !done_prev[k]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done dut=%0d", k);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_dut", 64'(k), 64'(mon_e.dut));
                    chk("sb_exited", 64'(exited_v[k]), 64'(mon_e.exited));
                    chk("sb_pass", 64'(pass_v[k]), 64'(mon_e.pass));
                    chk("sb_timeout", 64'(tmo_v[k]), 64'(mon_e.tmo));
                    chk("sb_fail_hart", 64'(fh_v[k]), 64'(mon_e.fh));
                    chk("sb_exit_code", 64'(code_v[k]), 64'(mon_e.code));
                    chk("sb_cycle_count", 64'(count_v[k]), 64'(mon_e.count));
                end
            end
            done_prev[k] = done_v[k];
        end
    end

    initial begin
        for (int k = 0; k < 4; k++) done_prev[k] = 1'b0;
        rst_v = 4'b0000;

        // All-exit pass: hart0 at cycle 10, hart1 at cycle 20.
        start(0);
        chk("rst_count", 64'(count_v[0]), 64'd0);
        chk("rst_flags", 64'({exited_v[0], done_v[0], pass_v[0], tmo_v[0], fh_v[0], code_v[0]}), 64'd0);
        idle(10);
        drive(0, 2'b01, 32'h1, 32'h0);
        idle(9);
        push(0, 2'b11, 1'b1, 1'b0, 1'b0, 31'd0, 32'd21);
        drive(0, 2'b10, 32'h0, 32'h1);
        idle(2);

        // Stop on first fail, then confirm DONE ignores later writes.
        start(0);
        idle(5);
        push(0, 2'b10, 1'b0, 1'b0, 1'b1, 31'd3, 32'd6);
        drive(0, 2'b10, 32'h0, 32'h7);
        idle(1);
        drive(0, 2'b01, 32'h1, 32'h0);
        idle(1);
        chk("done_frozen_exited", 64'(exited_v[0]), 64'h2);
        chk("done_frozen_count", 64'(count_v[0]), 64'd6);

        // Simultaneous fails: lowest index wins; later writes ignored.
        start(0);
        idle(3);
        push(0, 2'b11, 1'b0, 1'b0, 1'b0, 31'd2, 32'd4);
        drive(0, 2'b11, 32'h5, 32'h9);
        drive(0, 2'b11, 32'h3, 32'h3);
        idle(1);
        chk("simul_code_kept", 64'(code_v[0]), 64'd2);
        chk("simul_hart_kept", 64'(fh_v[0]), 64'd0);

        // Watchdog expiry with no writes.
        start(1);
        push(1, 2'b00, 1'b0, 1'b1, 1'b0, 31'd0, 32'd100);
        idle(103);
        chk("timeout_count_held", 64'(count_v[1]), 64'd100);

        // Proxy writes and repeat exits do not finish; then async reset mid-run.
        start(0);
        idle(2);
        drive(0, 2'b11, 32'h10, 32'h10);
        drive(0, 2'b01, 32'h1, 32'h0);
        drive(0, 2'b01, 32'h1, 32'h0);
        idle(3);
        chk("proxy_no_done", 64'(done_v[0]), 64'd0);
        chk("proxy_exited", 64'(exited_v[0]), 64'h1);
        chk("proxy_count", 64'(count_v[0]), 64'd8);
        #1 rst_v[0] = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_v[0]), 64'd0);
        chk("async_rst_flags", 64'({exited_v[0], done_v[0], pass_v[0], tmo_v[0], fh_v[0], code_v[0]}), 64'd0);

        // Any-exit mode: single exit passes; exit on the last watchdog cycle beats timeout.
        start(2);
        idle(3);
        push(2, 2'b10, 1'b1, 1'b0, 1'b0, 31'd0, 32'd4);
        drive(2, 2'b10, 32'h0, 32'h1);
        idle(1);
        start(2);
        idle(7);
        push(2, 2'b01, 1'b1, 1'b0, 1'b0, 31'd0, 32'd8);
        drive(2, 2'b01, 32'h1, 32'h0);
        idle(2);
        chk("exit_beats_timeout", 64'(tmo_v[2]), 64'd0);

        // No stop-on-fail: early fail is remembered and not overwritten by a later one.
        start(3);
        idle(2);
        drive(3, 2'b01, 32'h3, 32'h0);
        chk("nostop_no_done", 64'(done_v[3]), 64'd0);
        push(3, 2'b11, 1'b0, 1'b0, 1'b0, 31'd1, 32'd4);
        drive(3, 2'b10, 32'h0, 32'hB);
        idle(2);

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
